regfile_wb_scoreboard: RTL
==========================

// Module: regfile_wb_scoreboard
// PURPOSE
//  Controller in front of the 32x32 register file. Tracks pending destination writes (busy scoreboard).
//  Stalls instruction issue on RAW/WAW hazards and when the outstanding-write limit is reached.
//  Arbitrates two writeback requesters (ALU = wb0, load unit = wb1) onto the file's single write port.
//  Drives the file's RDaddr/RDdata/RegWrite inputs from registered outputs.
// PARAMETERS
//  MAX_PEND     8   maximum outstanding destination writes (1..31)
//  STARVE_LIMIT 4   consecutive cycles wb0 may wait before it gets priority (>=1)
// PORTS
//  clk_i            in   1   clock, all state on posedge
//  rst_n_i          in   1   synchronous reset, active low
//  issue_valid_i    in   1   decode presents an instruction
//  issue_rs_i       in   5   source register A
//  issue_rt_i       in   5   source register B
//  issue_rd_i       in   5   destination register
//  issue_wr_i       in   1   instruction writes issue_rd_i
//  issue_ready_o    out  1   issue accepted when valid&ready
//  wb0_valid_i      in   1   ALU writeback request
//  wb0_addr_i       in   5   ALU writeback register
//  wb0_data_i       in   32  ALU writeback data
//  wb0_ready_o      out  1   ALU request granted this cycle
//  wb1_valid_i      in   1   load writeback request
//  wb1_addr_i       in   5   load writeback register
//  wb1_data_i       in   32  load writeback data
//  wb1_ready_o      out  1   load request granted this cycle
//  rf_regwrite_o    out  2   to RegWrite: bit1 = write enable, bit0 = 0
//  rf_waddr_o       out  5   to RDaddr
//  rf_wdata_o       out  32  to RDdata
//  busy_o           out  32  scoreboard; bit0 always 0
//  err_o            out  1   sticky: writeback to a non-busy, nonzero register
// BEHAVIOUR
//  - Reset, synchronous: all outputs, busy, pend count, starve count and FSM cleared. FSM returns to LOAD_FIRST.
//    While rst_n_i=0, no grants and no issues. An in-flight registered write is dropped.
//  - issue_ready_o is combinational from registered state:
//    !busy[rs] & !busy[rt] & !(issue_wr_i & busy[rd]) & (pend < MAX_PEND | !issue_wr_i | rd==0).
//  - On issue with issue_wr_i=1 and rd!=0: busy[rd] set next edge and pend increments.
//  - Grant FSM:
//    LOAD_FIRST: wb1 wins a tie.
//    ALU_FIRST: wb0 wins a tie.
//    Only one grant per cycle. Grant (wbX_ready_o) is combinational; a request is consumed on valid&ready.
//  - Starve count increments each cycle wb0 is valid and not granted; it clears when wb0 is granted.
//    At STARVE_LIMIT the FSM goes LOAD_FIRST->ALU_FIRST. It returns after the first wb0 grant.
//  - Granted data registers into rf_* at the next edge (1-cycle latency). rf_regwrite_o=2'b10 for exactly one cycle.
//    The register file commits on the following edge. busy[addr] clears and pend decrements on that same edge.
//  - A grant to addr 0 is consumed, but no rf write occurs and busy/pend are untouched.
//  - A grant to a non-busy register (nonzero) performs the write, sets err_o (sticky until reset), leaves pend unchanged.
//  - Issue and commit on the same edge: pend is net unchanged.
//    Issue to rd while rd is committing is impossible: registered busy stalls it. The reg frees one cycle after commit.
//  - pend never wraps: issue is stalled at MAX_PEND, and decrement occurs only on a busy clear.
// STRUCTURE
//  - Shared package regfile_pkg:
//    REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REGWRITE_EN_BIT=1
//    arb_state_t {LOAD_FIRST, ALU_FIRST}
//  - Sub-module wb_arbiter: grant FSM plus starve counter.
//    Inputs: two valids. Outputs: two grants.
//  - The top level holds the scoreboard, pend counter, output register and err flag.
// TESTING
//  1 Reset mid-stream: busy=0x0000_0010, pend=1, rf_regwrite_o=2'b10, then rst_n_i=0 for 1 cycle
//    -> busy_o=0, rf_regwrite_o=0, issue_ready_o=1 the next cycle.
//  2 RAW stall: issue rd=5 wr=1, then rs=5 -> ready=0.
//    wb0 addr=5 data=0xDEAD_BEEF granted -> rf_* valid next cycle -> ready=1 one cycle after commit.
//  3 Tie: wb0 and wb1 both valid every cycle, STARVE_LIMIT=4 -> wb1 granted 4 cycles, then wb0 once, then wb1 again.
//  4 Limit: MAX_PEND=8, issue 8 writes to rd=1..8 -> 9th (rd=9) ready=0.
//    One commit -> ready=1. Commit and new issue on the same edge -> pend stays 8.
//  5 Corners: wb1 addr=0 -> wb1_ready_o=1, no rf write, err_o=0.
//    wb0 addr=12 while busy[12]=0 -> write to reg 12 occurs, err_o=1 and stays set.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, constants and arbiter state encoding for the register-file
// writeback controller.
package regfile_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DATA_W          = 32;
  localparam int NUM_REGS        = 32;
  localparam int REGWRITE_EN_BIT = 1;

  typedef enum logic {
    LOAD_FIRST = 1'b0,
    ALU_FIRST  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter. The load unit normally wins a tie. The ALU
// is promoted for one grant once it has waited STARVE_LIMIT cycles.
//
// state      | meaning
// LOAD_FIRST | wb1 (load) wins a tie; starvation of wb0 is being counted
// ALU_FIRST  | wb0 (ALU) wins a tie; left again after the first wb0 grant
module wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic wb0_valid_i,
  input  logic wb1_valid_i,
  output logic wb0_grant_o,
  output logic wb1_grant_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  // Grant selection, starvation counting and priority hand-over.
  always_comb begin
    wb0_grant_o = 1'b0;
    wb1_grant_o = 1'b0;
    starve_d    = starve_q;
    state_d     = state_q;

    // Grants are suppressed while reset is asserted.
    if (rst_n_i) begin
      if (state_q == ALU_FIRST) begin
        wb0_grant_o = wb0_valid_i;
        wb1_grant_o = wb1_valid_i & ~wb0_valid_i;
      end else begin
        wb1_grant_o = wb1_valid_i;
        wb0_grant_o = wb0_valid_i & ~wb1_valid_i;
      end
    end

    // The counter saturates at the limit so it can never wrap.
    if (wb0_grant_o) begin
      starve_d = '0;
    end else if (wb0_valid_i && (starve_q != LIMIT)) begin
      starve_d = starve_q + CNT_W'(1);
    end

    case (state_q)
      LOAD_FIRST: if (starve_d == LIMIT) state_d = ALU_FIRST;
      ALU_FIRST:  if (wb0_grant_o)       state_d = LOAD_FIRST;
      default:                           state_d = LOAD_FIRST;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= LOAD_FIRST;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Controller in front of the 32x32 register file: busy scoreboard with an
// outstanding-write limit, issue stall on RAW/WAW hazards, and a registered
// single write port fed by the two writeback requesters.
module regfile_wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int MAX_PEND     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs_i,
  input  logic [REG_ADDR_W-1:0] issue_rt_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_wr_i,
  output logic                  issue_ready_o,
  input  logic                  wb0_valid_i,
  input  logic [REG_ADDR_W-1:0] wb0_addr_i,
  input  logic [DATA_W-1:0]     wb0_data_i,
  output logic                  wb0_ready_o,
  input  logic                  wb1_valid_i,
  input  logic [REG_ADDR_W-1:0] wb1_addr_i,
  input  logic [DATA_W-1:0]     wb1_data_i,
  output logic                  wb1_ready_o,
  output logic [1:0]            rf_regwrite_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic [NUM_REGS-1:0]   busy_o,
  output logic                  err_o
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [PEND_W-1:0]     pend_q, pend_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  err_q, err_d;

  logic                  grant_any;
  logic [REG_ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0]     grant_data;
  logic                  issue_set;
  logic                  commit_hit;

  wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .wb0_valid_i (wb0_valid_i),
    .wb1_valid_i (wb1_valid_i),
    .wb0_grant_o (wb0_ready_o),
    .wb1_grant_o (wb1_ready_o)
  );

  // Issue acceptance from registered state only; a committing register
  // still reads busy, so it frees one cycle after its commit edge.
  always_comb begin
    issue_ready_o = rst_n_i
                  & ~busy_q[issue_rs_i]
                  & ~busy_q[issue_rt_i]
                  & ~(issue_wr_i & busy_q[issue_rd_i])
                  & ((pend_q < PEND_MAX) | ~issue_wr_i | (issue_rd_i == '0));
    issue_set     = issue_valid_i & issue_ready_o & issue_wr_i
                  & (issue_rd_i != '0);
  end

  // Writeback mux; grants are one-hot so wb0 selection is sufficient.
  always_comb begin
    grant_any  = wb0_ready_o | wb1_ready_o;
    grant_addr = wb0_ready_o ? wb0_addr_i : wb1_addr_i;
    grant_data = wb0_ready_o ? wb0_data_i : wb1_data_i;
  end

  // Next state for scoreboard, pending count, write port and error flag.
  // The commit happens on the edge after the write port is loaded.
  always_comb begin
    commit_hit = rf_we_q & busy_q[rf_waddr_q];

    busy_d = busy_q;
    if (commit_hit) busy_d[rf_waddr_q] = 1'b0;
    if (issue_set)  busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    pend_d = pend_q;
    case ({issue_set, commit_hit})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    // A write to r0 is consumed without touching the file.
    rf_we_d    = grant_any & (grant_addr != '0);
    rf_waddr_d = rf_we_d ? grant_addr : rf_waddr_q;
    rf_wdata_d = rf_we_d ? grant_data : rf_wdata_q;

    err_d = err_q | (rf_we_q & ~busy_q[rf_waddr_q]);
  end

  // State registers; reset drops any in-flight write.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q     <= '0;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  // Register file drive.
  always_comb begin
    rf_regwrite_o                  = 2'b00;
    rf_regwrite_o[REGWRITE_EN_BIT] = rf_we_q;
    rf_waddr_o                     = rf_waddr_q;
    rf_wdata_o                     = rf_wdata_q;
    busy_o                         = busy_q;
    err_o                          = err_q;
  end

endmodule
